fifo_rd_ctrl: RTL

//  Read-side pointer and flag controller of the asynchronous FIFO; runs entirely in rd_clk.

---
 rtl/fifo_rd_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller for an asynchronous FIFO, clocked by rd_clk.
// Tracks the binary/Gray read pointer and derives empty, almost-empty, fill level and underflow.
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH       = 6,
    parameter int ALMOST_EMPTY_THR = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  rd_en,
    input  logic                  rd_underflow_clr,
    input  logic [ADDR_WIDTH:0]   wr_ptr_sync,
    output logic                  rd_fire,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  rd_underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] THR_P = PW'(ALMOST_EMPTY_THR);

    logic [PW-1:0] rd_bin_q, rd_bin_d;
    logic [PW-1:0] rd_gray_q, rd_gray_d;
    logic [PW-1:0] rd_level_q, rd_level_d;
    logic          rd_empty_q, rd_empty_d;
    logic          rd_almost_empty_q, rd_almost_empty_d;
    logic          rd_underflow_q, rd_underflow_d;
    logic [PW-1:0] wr_bin_sync;

    // Each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wr_bin_sync[gi] = ^(wr_ptr_sync >> gi);
        end
    endgenerate

    assign rd_fire = rd_en & ~rd_empty_q;

    always_comb begin
        rd_bin_d          = rd_bin_q + PW'(rd_fire);
        rd_gray_d         = rd_bin_d ^ (rd_bin_d >> 1);
        rd_level_d        = wr_bin_sync - rd_bin_d;
        rd_empty_d        = (rd_gray_d == wr_ptr_sync);
        rd_almost_empty_d = (rd_level_d <= THR_P);
        rd_underflow_d    = (rd_en & rd_empty_q) | (rd_underflow_q & ~rd_underflow_clr);
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_bin_q          <= '0;
            rd_gray_q         <= '0;
            rd_level_q        <= '0;
            rd_empty_q        <= 1'b1;
            rd_almost_empty_q <= 1'b1;
            rd_underflow_q    <= 1'b0;
        end else begin
            rd_bin_q          <= rd_bin_d;
            rd_gray_q         <= rd_gray_d;
            rd_level_q        <= rd_level_d;
            rd_empty_q        <= rd_empty_d;
            rd_almost_empty_q <= rd_almost_empty_d;
            rd_underflow_q    <= rd_underflow_d;
        end
    end

    assign rd_addr         = rd_bin_q[ADDR_WIDTH-1:0];
    assign rd_ptr          = rd_gray_q;
    assign rd_empty        = rd_empty_q;
    assign rd_almost_empty = rd_almost_empty_q;
    assign rd_level        = rd_level_q;
    assign rd_underflow    = rd_underflow_q;

endmodule
